// File: rtl/sync_p2p_rx.sv
// Destination side of the toggle-level pulse crossing: synchronizes a_level, emits pulses, queues events, returns ack.
// Optional statistics outputs (evt_total, drop_total) are enabled by defining SYNC_P2P_RX_STATS_EN.
module sync_p2p_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4,
    parameter int ACK_MODE    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_level,
    output logic             ack_level,
    output logic             b_level,
    output logic             b_level_d,
    output logic             b_pulse,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CNT_W-1:0] pend_cnt,
    output logic             overflow,
    input  logic             ovf_clr
`ifdef SYNC_P2P_RX_STATS_EN
    ,
    output logic [15:0]      evt_total,
    output logic [15:0]      drop_total
`endif
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   b_level_d_reg;
    logic [CNT_W-1:0]       pend_cnt_reg;
    logic                   overflow_reg;
    logic                   ack_reg;
    logic                   inc;
    logic                   dec;
    logic                   full;
    logic                   drop;

    // Pure flop chain: nothing may sit between stages or metastability settling time is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg      <= '0;
            b_level_d_reg <= 1'b0;
        end else begin
            sync_reg      <= {sync_reg[SYNC_STAGES-2:0], a_level};
            b_level_d_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign b_level   = sync_reg[SYNC_STAGES-1];
    assign b_level_d = b_level_d_reg;
    assign b_pulse   = b_level ^ b_level_d_reg;

    assign evt_valid = (pend_cnt_reg != '0);
    assign inc       = b_pulse;
    assign dec       = evt_valid & evt_ready;
    assign full      = &pend_cnt_reg;
    assign drop      = inc & ~dec & full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_cnt_reg <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (inc && !dec && !full)
                pend_cnt_reg <= pend_cnt_reg + CNT_W'(1);
            else if (dec && !inc)
                pend_cnt_reg <= pend_cnt_reg - CNT_W'(1);

            // A new drop outranks a simultaneous clear so no loss goes unreported.
            if (drop)
                overflow_reg <= 1'b1;
            else if (ovf_clr)
                overflow_reg <= 1'b0;
        end
    end

    assign pend_cnt = pend_cnt_reg;
    assign overflow = overflow_reg;

    generate
        if (ACK_MODE == 0) begin : g_ack_rx
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    ack_reg <= 1'b0;
                else
                    ack_reg <= b_level_d_reg;
            end
        end else begin : g_ack_consume
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    ack_reg <= 1'b0;
                else if (dec)
                    ack_reg <= ~ack_reg;
            end
        end
    endgenerate

    assign ack_level = ack_reg;

`ifdef SYNC_P2P_RX_STATS_EN
    logic [15:0] evt_total_reg;
    logic [15:0] drop_total_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_total_reg  <= '0;
            drop_total_reg <= '0;
        end else begin
            if (inc)
                evt_total_reg <= evt_total_reg + 16'd1;
            if (drop)
                drop_total_reg <= drop_total_reg + 16'd1;
        end
    end

    assign evt_total  = evt_total_reg;
    assign drop_total = drop_total_reg;
`endif

endmodule

// File: tb/tb_sync_p2p_rx.sv
// Bench for sync_p2p_rx: two instances (ACK_MODE 0 and 1) share stimulus and are checked every cycle against a history-based model.
module tb_sync_p2p_rx;

    localparam int SYNC = 2;
    localparam int CW   = 4;
    localparam int MAXC = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic a_level = 1'b0;
    logic evt_ready = 1'b0;
    logic ovf_clr = 1'b0;

    logic          ack0, bl0, bld0, bp0, ev0, ov0;
    logic [CW-1:0] pc0;
    logic          ack1, bl1, bld1, bp1, ev1, ov1;
    logic [CW-1:0] pc1;
`ifdef SYNC_P2P_RX_STATS_EN
    logic [15:0] et0, dt0, et1, dt1;
`endif

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sync_p2p_rx #(.SYNC_STAGES(SYNC), .CNT_W(CW), .ACK_MODE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .a_level(a_level), .ack_level(ack0),
        .b_level(bl0), .b_level_d(bld0), .b_pulse(bp0), .evt_valid(ev0),
        .evt_ready(evt_ready), .pend_cnt(pc0), .overflow(ov0), .ovf_clr(ovf_clr)
`ifdef SYNC_P2P_RX_STATS_EN
        , .evt_total(et0), .drop_total(dt0)
`endif
    );

    sync_p2p_rx #(.SYNC_STAGES(SYNC), .CNT_W(CW), .ACK_MODE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .a_level(a_level), .ack_level(ack1),
        .b_level(bl1), .b_level_d(bld1), .b_pulse(bp1), .evt_valid(ev1),
        .evt_ready(evt_ready), .pend_cnt(pc1), .overflow(ov1), .ovf_clr(ovf_clr)
`ifdef SYNC_P2P_RX_STATS_EN
        , .evt_total(et1), .drop_total(dt1)
`endif
    );

    // Model: a_level sampled at each edge (newest first), event count, overflow, accept parity, totals.
    bit hist[$];
    int m_cnt = 0;
    bit m_ovf = 0;
    bit m_ack1 = 0;
    int m_evt = 0;
    int m_drop = 0;

    function automatic bit hv(input int d);
        return (hist.size() > d) ? hist[d] : 1'b0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit pulse, acc, dropped;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                hist.delete();
                m_cnt = 0; m_ovf = 0; m_ack1 = 0; m_evt = 0; m_drop = 0;
            end else begin
                pulse   = hv(SYNC-1) ^ hv(SYNC);
                acc     = (m_cnt != 0) && evt_ready;
                dropped = pulse && !acc && (m_cnt == MAXC);
                if (pulse && !acc && !dropped) m_cnt = m_cnt + 1;
                else if (acc && !pulse) m_cnt = m_cnt - 1;
                if (dropped) m_ovf = 1;
                else if (ovf_clr) m_ovf = 0;
                if (acc) m_ack1 = !m_ack1;
                if (pulse) m_evt = m_evt + 1;
                if (dropped) m_drop = m_drop + 1;
                hist.push_front(a_level);
                if (hist.size() > 8) void'(hist.pop_back());
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("b_level", 32'(bl0), 32'(hv(SYNC-1)));
                chk("b_level_d", 32'(bld0), 32'(hv(SYNC)));
                chk("b_pulse", 32'(bp0), 32'(hv(SYNC-1) ^ hv(SYNC)));
                chk("evt_valid", 32'(ev0), 32'(m_cnt != 0));
                chk("pend_cnt", 32'(pc0), 32'(m_cnt));
                chk("overflow", 32'(ov0), 32'(m_ovf));
                chk("ack_mode0", 32'(ack0), 32'(hv(SYNC+1)));
                chk("ack_mode1", 32'(ack1), 32'(m_ack1));
                chk("m1_pend_cnt", 32'(pc1), 32'(m_cnt));
                chk("m1_b_pulse", 32'(bp1), 32'(hv(SYNC-1) ^ hv(SYNC)));
                chk("m1_evt_valid", 32'(ev1), 32'(m_cnt != 0));
                chk("m1_overflow", 32'(ov1), 32'(m_ovf));
                chk("m1_b_level", 32'(bl1), 32'(hv(SYNC-1)));
                chk("m1_b_level_d", 32'(bld1), 32'(hv(SYNC)));
`ifdef SYNC_P2P_RX_STATS_EN
                chk("evt_total", 32'(et0), 32'(m_evt[15:0]));
                chk("drop_total", 32'(dt0), 32'(m_drop[15:0]));
                chk("m1_evt_total", 32'(et1), 32'(m_evt[15:0]));
                chk("m1_drop_total", 32'(dt1), 32'(m_drop[15:0]));
`endif
            end
        end
    end

    task automatic toggles(input int n);
        for (int i = 0; i < n; i++) begin
            a_level = ~a_level;
            repeat (4) step();
        end
    endtask

    initial begin
        // Reset state
        repeat (3) step();
        chk("rst_pend", 32'(pc0), 32'd0);
        chk("rst_valid", 32'(ev0), 32'd0);
        chk("rst_ovf", 32'(ov0), 32'd0);
        chk("rst_ack", 32'(ack0), 32'd0);
        chk("rst_pulse", 32'(bp0), 32'd0);
        rst_n = 1'b1;
        repeat (20) step();
        chk("idle_pend", 32'(pc0), 32'd0);
        chk("idle_ack", 32'(ack0), 32'd0);

        // Single event latency with ready held high
        evt_ready = 1'b1;
        a_level = 1'b1;
        step(); chk("lat_e1_pulse", 32'(bp0), 32'd0);
        step(); chk("lat_e2_pulse", 32'(bp0), 32'd1);
        chk("lat_e2_pend", 32'(pc0), 32'd0);
        step(); chk("lat_e3_pulse", 32'(bp0), 32'd0);
        chk("lat_e3_pend", 32'(pc0), 32'd1);
        chk("lat_e3_ack0", 32'(ack0), 32'd0);
        step(); chk("lat_e4_pend", 32'(pc0), 32'd0);
        chk("lat_e4_ack0", 32'(ack0), 32'd1);
        chk("lat_e4_ack1", 32'(ack1), 32'd1);
        evt_ready = 1'b0;
        repeat (3) step();

        // Fill to full, then one dropped event
        toggles(15);
        chk("fill_pend", 32'(pc0), 32'd15);
        chk("fill_ovf", 32'(ov0), 32'd0);
        toggles(1);
        chk("drop_pend", 32'(pc0), 32'd15);
        chk("drop_ovf", 32'(ov0), 32'd1);
        evt_ready = 1'b1;
        repeat (14) step();
        chk("drain14_pend", 32'(pc0), 32'd1);
        step();
        chk("drain15_pend", 32'(pc0), 32'd0);
        chk("drain15_valid", 32'(ev0), 32'd0);
        evt_ready = 1'b0;
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        chk("clr_ovf", 32'(ov0), 32'd0);

        // Full counter, accept coincides with the pulse
        toggles(15);
        a_level = ~a_level;
        step(); step();
        chk("fullacc_pulse", 32'(bp0), 32'd1);
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        chk("fullacc_pend", 32'(pc0), 32'd15);
        chk("fullacc_ovf", 32'(ov0), 32'd0);
        repeat (2) step();

        // Drop together with ovf_clr: set wins, then clear alone
        toggles(1);
        chk("ovf_set", 32'(ov0), 32'd1);
        a_level = ~a_level;
        step(); step();
        ovf_clr = 1'b1;
        step();
        chk("ovf_set_wins", 32'(ov0), 32'd1);
        step();
        ovf_clr = 1'b0;
        chk("ovf_clr_alone", 32'(ov0), 32'd0);

        // ACK_MODE=1: ack only on consumption
        a_level = 1'b0;
        rst_n = 1'b0; step(); rst_n = 1'b1;
        repeat (5) step();
        chk("rst_mid_pend", 32'(pc0), 32'd0);
        a_level = 1'b1;
        repeat (10) step();
        chk("m1_hold_ack", 32'(ack1), 32'd0);
        chk("m1_hold_pend", 32'(pc1), 32'd1);
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        chk("m1_acc_ack", 32'(ack1), 32'd1);
        chk("m1_acc_pend", 32'(pc1), 32'd0);

        // Reset released with a_level high gives exactly one event
        rst_n = 1'b0; step(); rst_n = 1'b1;
        repeat (5) step();
        chk("rst_hi_pend", 32'(pc0), 32'd1);
        repeat (10) step();
        chk("rst_hi_pend_hold", 32'(pc0), 32'd1);

        // Randomized phase
        for (int blk = 0; blk < 40; blk++) begin
            int rdy_pct;
            rdy_pct = (blk % 3 == 0) ? 5 : int'($urandom_range(20, 90));
            for (int t = 0; t < 12; t++) begin
                int hold;
                hold = int'($urandom_range(SYNC + 1, SYNC + 6));
                for (int c = 0; c < hold; c++) begin
                    evt_ready = ($urandom_range(0, 99) < rdy_pct);
                    ovf_clr   = ($urandom_range(0, 19) == 0);
                    step();
                end
                a_level = ~a_level;
            end
            if ($urandom_range(0, 9) == 0) begin
                rst_n = 1'b0; step(); rst_n = 1'b1;
            end
        end
        evt_ready = 1'b0;
        ovf_clr = 1'b0;
        repeat (6) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
